uart_frame_ctrl: RTL

Frame controller that sits directly behind the LED-panel UART receiver and sequences its byte stream into fixed-length panel update frames. It hunts for a sync byte, then writes each payload byte to the panel frame buffer through a simple write port. It checks a modulo-256 checksum and enforces an inter-byte timeout. A committed frame is signalled with a one-cycle `o_Frame_Valid`; a discarded frame is signalled with a one-cycle `o_Frame_Error` plus a cause code.

---
 rtl/uart_frame_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_frame_ctrl.sv
// Frame controller behind the LED-panel UART receiver: hunts for a sync byte,
// streams payload bytes into the frame buffer, checks a mod-256 checksum and an inter-byte timeout.
module uart_frame_ctrl #(
  parameter int         CLKS_PER_BIT  = 217,
  parameter int         PAYLOAD_LEN   = 16,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic                           i_Clock,
  input  logic                           i_Rst_L,
  input  logic                           i_RX_DV,
  input  logic [7:0]                     i_RX_Byte,
  output logic                           o_Wr_En,
  output logic [$clog2(PAYLOAD_LEN)-1:0] o_Wr_Addr,
  output logic [7:0]                     o_Wr_Data,
  output logic                           o_Frame_Valid,
  output logic                           o_Frame_Error,
  output logic [1:0]                     o_Err_Code,
  output logic                           o_Busy
);

  localparam int TIMEOUT_CLKS = CLKS_PER_BIT * 10 * TIMEOUT_BYTES;
  localparam int IDX_W        = $clog2(PAYLOAD_LEN);
  localparam int GAP_W        = $clog2(TIMEOUT_CLKS);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_CHECKSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    PAYLOAD  = 2'd1,
    CHECKSUM = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             wr_en_q, wr_en_d;
  logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_error_q, frame_error_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             busy_q, busy_d;

  logic             timeout_hit;
  logic             sum_match;

  // A byte arriving in the terminal cycle wins over the timeout.
  assign timeout_hit = (state_q != HUNT) && !i_RX_DV && (gap_q == GAP_LAST);
  assign sum_match   = (i_RX_Byte == sum_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= HUNT;
      idx_q   <= '0;
      sum_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      gap_q   <= gap_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    gap_d   = '0;

    unique case (state_q)
      HUNT: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
          state_d = PAYLOAD;
          idx_d   = '0;
          sum_d   = '0;
        end
      end

      PAYLOAD: begin
        if (i_RX_DV) begin
          sum_d = sum_q + i_RX_Byte;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) begin
            state_d = CHECKSUM;
          end
        end else if (timeout_hit) begin
          state_d = HUNT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      CHECKSUM: begin
        if (i_RX_DV || timeout_hit) begin
          state_d = HUNT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: state_d = HUNT;
    endcase
  end

  // Output decode: next values for the registered outputs.
  always_comb begin
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    err_code_d    = err_code_q;
    busy_d        = (state_d != HUNT);

    if ((state_q == PAYLOAD) && i_RX_DV) begin
      wr_en_d   = 1'b1;
      wr_addr_d = idx_q;
      wr_data_d = i_RX_Byte;
    end

    if ((state_q == CHECKSUM) && i_RX_DV) begin
      if (sum_match) begin
        frame_valid_d = 1'b1;
      end else begin
        frame_error_d = 1'b1;
        err_code_d    = ERR_CHECKSUM;
      end
    end else if (timeout_hit) begin
      frame_error_d = 1'b1;
      err_code_d    = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= ERR_NONE;
      busy_q        <= 1'b0;
    end else begin
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign o_Wr_En       = wr_en_q;
  assign o_Wr_Addr     = wr_addr_q;
  assign o_Wr_Data     = wr_data_q;
  assign o_Frame_Valid = frame_valid_q;
  assign o_Frame_Error = frame_error_q;
  assign o_Err_Code    = err_code_q;
  assign o_Busy        = busy_q;

endmodule
